decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/y86_pkg.sv | 57 +++++
 rtl/decode_scoreboard.sv | 48 ++++
 rtl/decode_stage.sv | 131 +++++++++++++
 tb/tb_decode_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode and register constants, decode result type and field decoder
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE       = 4'hF;
  localparam logic [3:0] RSP_DEFAULT = 4'h4;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       err;
  } decode_t;

  function automatic decode_t decode_fields(
    input logic [3:0] icode,
    input logic [3:0] ra,
    input logic [3:0] rb,
    input logic [3:0] rsp
  );
    decode_t d;
    logic    need_ra;
    logic    need_rb;
    d       = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE, err: 1'b0};
    need_ra = 1'b0;
    need_rb = 1'b0;
    case (icode)
      I_RRMOVQ: begin d.src_a = ra; d.dst_e = rb; need_ra = 1'b1; need_rb = 1'b1; end
      I_IRMOVQ: begin d.dst_e = rb; need_rb = 1'b1; end
      I_RMMOVQ: begin d.src_a = ra; d.src_b = rb; need_ra = 1'b1; need_rb = 1'b1; end
      I_MRMOVQ: begin d.src_b = rb; d.dst_m = ra; need_ra = 1'b1; need_rb = 1'b1; end
      I_OPQ:    begin d.src_a = ra; d.src_b = rb; d.dst_e = rb; need_ra = 1'b1; need_rb = 1'b1; end
      I_CALL:   begin d.src_b = rsp; d.dst_e = rsp; end
      I_RET:    begin d.src_a = rsp; d.src_b = rsp; d.dst_e = rsp; end
      I_PUSHQ:  begin d.src_a = ra; d.src_b = rsp; d.dst_e = rsp; need_ra = 1'b1; end
      I_POPQ:   begin d.src_a = rsp; d.src_b = rsp; d.dst_e = rsp; d.dst_m = ra; need_ra = 1'b1; end
      I_HALT, I_NOP, I_JXX: ;
      default: ;
    endcase
    d.err = (icode > I_POPQ) || (need_ra && ra == RNONE) || (need_rb && rb == RNONE);
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - pending-destination bits with set/clear and source hazard lookup
module decode_scoreboard
  import y86_pkg::*;
#(
  parameter int NREG = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_set_en,
  input  logic [3:0] i_set_e,
  input  logic [3:0] i_set_m,
  input  logic       i_clr_en,
  input  logic [3:0] i_clr_idx,
  input  logic [3:0] i_src_a,
  input  logic [3:0] i_src_b,
  output logic       o_hazard
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  always_comb begin
    w_set    = '0;
    w_clr    = '0;
    o_hazard = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (4'(i) != RNONE) begin
        if (i_set_en && (i_set_e == 4'(i) || i_set_m == 4'(i))) w_set[i] = 1'b1;
        if (i_clr_en && i_clr_idx == 4'(i)) w_clr[i] = 1'b1;
        if (r_pending[i] && (i_src_a == 4'(i) || i_src_b == 4'(i))) o_hazard = 1'b1;
      end
    end
  end

  // Clear is applied before set so a same-cycle retire cannot drop a fresh claim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (i_flush) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Y86-64 decode stage with one output register; DECODE_SCOREBOARD_EN enables hazard stalls
module decode_stage
  import y86_pkg::*;
#(
  parameter int         XLEN   = 64,
  parameter int         NREG   = 15,
  parameter logic [3:0] RSP_ID = RSP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_icode,
  input  logic [3:0]      in_ifun,
  input  logic [3:0]      in_ra,
  input  logic [3:0]      in_rb,
  input  logic [XLEN-1:0] in_valc,
  input  logic [XLEN-1:0] in_valp,
  output logic [3:0]      rd_addr_a,
  output logic [3:0]      rd_addr_b,
  input  logic [XLEN-1:0] rd_data_a,
  input  logic [XLEN-1:0] rd_data_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_icode,
  output logic [3:0]      out_ifun,
  output logic [XLEN-1:0] out_vala,
  output logic [XLEN-1:0] out_valb,
  output logic [XLEN-1:0] out_valc,
  output logic [XLEN-1:0] out_valp,
  output logic [3:0]      out_dste,
  output logic [3:0]      out_dstm,
  output logic            out_err,
  input  logic            wb_valid,
  input  logic [3:0]      wb_dst,
  input  logic            flush
);

  decode_t         w_dec;
  logic            w_hazard_raw;
  logic            w_hazard;
  logic            w_accept;
  logic [XLEN-1:0] w_vala;
  logic [XLEN-1:0] w_valb;

  logic            r_valid;
  logic [3:0]      r_icode;
  logic [3:0]      r_ifun;
  logic [XLEN-1:0] r_vala;
  logic [XLEN-1:0] r_valb;
  logic [XLEN-1:0] r_valc;
  logic [XLEN-1:0] r_valp;
  logic [3:0]      r_dste;
  logic [3:0]      r_dstm;
  logic            r_err;

  assign w_dec     = decode_fields(in_icode, in_ra, in_rb, RSP_ID);
  assign rd_addr_a = w_dec.src_a;
  assign rd_addr_b = w_dec.src_b;
  assign w_vala    = (w_dec.src_a == RNONE) ? '0 : rd_data_a;
  assign w_valb    = (w_dec.src_b == RNONE) ? '0 : rd_data_b;

`ifdef DECODE_SCOREBOARD_EN
  decode_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (flush),
    .i_set_en  (w_accept && !w_dec.err),
    .i_set_e   (w_dec.dst_e),
    .i_set_m   (w_dec.dst_m),
    .i_clr_en  (wb_valid),
    .i_clr_idx (wb_dst),
    .i_src_a   (w_dec.src_a),
    .i_src_b   (w_dec.src_b),
    .o_hazard  (w_hazard_raw)
  );
`else
  logic w_unused_sb;
  assign w_hazard_raw = 1'b0;
  assign w_unused_sb  = ^{wb_valid, wb_dst, 1'(NREG)};
`endif

  // Faulting instructions write nothing, so they must not wait on older writers.
  assign w_hazard = w_hazard_raw && !w_dec.err;
  assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_icode <= 4'h0;
      r_ifun  <= 4'h0;
      r_vala  <= '0;
      r_valb  <= '0;
      r_valc  <= '0;
      r_valp  <= '0;
      r_dste  <= RNONE;
      r_dstm  <= RNONE;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_icode <= in_icode;
      r_ifun  <= in_ifun;
      r_vala  <= w_vala;
      r_valb  <= w_valb;
      r_valc  <= in_valc;
      r_valp  <= in_valp;
      r_dste  <= w_dec.dst_e;
      r_dstm  <= w_dec.dst_m;
      r_err   <= w_dec.err;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_icode = r_icode;
  assign out_ifun  = r_ifun;
  assign out_vala  = r_vala;
  assign out_valb  = r_valb;
  assign out_valc  = r_valc;
  assign out_valp  = r_valp;
  assign out_dste  = r_dste;
  assign out_dstm  = r_dstm;
  assign out_err   = r_err;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage, follows DECODE_SCOREBOARD_EN when defined
`timescale 1ns/1ps
module tb_decode_stage;

  localparam logic [3:0] RSP = 4'h4;
  localparam logic [3:0] RN  = 4'hF;
`ifdef DECODE_SCOREBOARD_EN
  localparam int SB_ON = 1;
`else
  localparam int SB_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode, in_ifun, in_ra, in_rb;
  logic [63:0] in_valc, in_valp;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [63:0] rd_data_a, rd_data_b;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode, out_ifun, out_dste, out_dstm;
  logic [63:0] out_vala, out_valb, out_valc, out_valp;
  logic        out_err;
  logic        wb_valid;
  logic [3:0]  wb_dst;
  logic        flush;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [63:0] rf[16];
  bit          pend[16];
  bit          m_acc;
  int          n_checks = 0;
  int          n_fail   = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_ra(in_ra), .in_rb(in_rb),
    .in_valc(in_valc), .in_valp(in_valp),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_ifun(out_ifun),
    .out_vala(out_vala), .out_valb(out_valb), .out_valc(out_valc), .out_valp(out_valp),
    .out_dste(out_dste), .out_dstm(out_dstm), .out_err(out_err),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush)
  );

  always #5 clk = ~clk;

  assign rd_data_a = rf[rd_addr_a];
  assign rd_data_b = rf[rd_addr_b];

  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return RSP;
    return RN;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
    return RN;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
    return RN;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return RN;
  endfunction

  function automatic logic m_err(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    return (ic > 4'hB) ||
           (ic inside {4'h2, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB} && ra == RN) ||
           (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6} && rb == RN);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_instr(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [3:0] ra, input logic [3:0] rb);
    in_icode = ic;
    in_ifun  = fn;
    in_ra    = ra;
    in_rb    = rb;
    in_valc  = {$urandom, $urandom};
    in_valp  = {$urandom, $urandom};
  endtask

  // One clock: predict in_ready, check it mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic       exp_rdy;
    logic       haz;
    logic [3:0] sa, sb;
    logic       er;
    exp_t       e;
    sa  = m_src_a(in_icode, in_ra);
    sb  = m_src_b(in_icode, in_rb);
    er  = m_err(in_icode, in_ra, in_rb);
    haz = (SB_ON != 0) && !er && (pend[sa] || pend[sb]);
    exp_rdy = (q.size() == 0 || out_ready) && !haz && !flush;
    @(negedge clk);
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    m_acc = in_valid && exp_rdy;
    if (flush) begin
      q.delete();
      foreach (pend[i]) pend[i] = 0;
    end else begin
      if (m_acc) begin
        e.icode = in_icode;
        e.ifun  = in_ifun;
        e.vala  = (sa == RN) ? 64'd0 : rf[sa];
        e.valb  = (sb == RN) ? 64'd0 : rf[sb];
        e.valc  = in_valc;
        e.valp  = in_valp;
        e.dste  = m_dst_e(in_icode, in_rb);
        e.dstm  = m_dst_m(in_icode, in_ra);
        e.err   = er;
        q.push_back(e);
      end
      if (SB_ON != 0) begin
        if (wb_valid && wb_dst != RN) pend[wb_dst] = 0;
        if (m_acc && !er) begin
          if (e.dste != RN) pend[e.dste] = 1;
          if (e.dstm != RN) pend[e.dstm] = 1;
        end
      end
    end
    #1;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb, output int cyc);
    set_instr(ic, fn, ra, rb);
    in_valid = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (m_acc) begin
        cyc = k;
        break;
      end
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(cyc != 0), 64'd1);
  endtask

  task automatic retire(input logic [3:0] r);
    wb_valid = 1'b1;
    wb_dst   = r;
    tick();
    wb_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t h;
    chk("out_valid", out_valid, 64'(q.size() != 0));
    if (out_valid && q.size() != 0) begin
      h = q[0];
      chk("out_icode", out_icode, h.icode);
      chk("out_ifun",  out_ifun,  h.ifun);
      chk("out_vala",  out_vala,  h.vala);
      chk("out_valb",  out_valb,  h.valb);
      chk("out_valc",  out_valc,  h.valc);
      chk("out_valp",  out_valp,  h.valp);
      chk("out_dste",  out_dste,  h.dste);
      chk("out_dstm",  out_dstm,  h.dstm);
      chk("out_err",   out_err,   h.err);
      if (out_ready) void'(q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int acc_at;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_dst = RN; flush = 1'b0;
    set_instr(4'h1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) rf[i] = {$urandom, $urandom} | 64'h1;
    rf[1] = 64'd5;
    rf[2] = 64'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_out_err",   out_err,   64'd0);
    chk("rst_out_icode", out_icode, 64'd0);
    chk("rst_out_ifun",  out_ifun,  64'd0);
    chk("rst_out_dste",  out_dste,  64'hF);
    chk("rst_out_dstm",  out_dstm,  64'hF);
    chk("rst_out_vala",  out_vala,  64'd0);
    chk("rst_out_valb",  out_valb,  64'd0);
    chk("rst_out_valc",  out_valc,  64'd0);
    chk("rst_out_valp",  out_valp,  64'd0);
    rst_n = 1'b1;

    // OPq rA=1 rB=2 reads 5 and 7
    send(4'h6, 4'h0, 4'h1, 4'h2, cyc);
    chk("opq_first_cycle", cyc, 64'd1);
    tick();
    retire(4'h2);

    // mrmovq claims r3, dependent OPq waits for its retire
    send(4'h5, 4'h0, 4'h3, 4'h1, cyc);
    set_instr(4'h6, 4'h1, 4'h3, 4'h2);
    in_valid = 1'b1;
    acc_at = -1;
    for (int k = 0; k < 6; k++) begin
      wb_valid = (k == 3);
      wb_dst   = 4'h3;
      tick();
      if (m_acc && acc_at < 0) begin
        acc_at   = k;
        in_valid = 1'b0;
      end
    end
    wb_valid = 1'b0;
    chk("raw_accept_cycle", 64'(acc_at), (SB_ON != 0) ? 64'd4 : 64'd0);
    retire(4'h2);

    // downstream backpressure then back-to-back accepts
    out_ready = 1'b0;
    send(4'h6, 4'h0, 4'h1, 4'h5, cyc);
    set_instr(4'h1, 4'h0, 4'h0, 4'h0);
    in_valid = 1'b1;
    repeat (3) tick();
    chk("bp_no_accept", m_acc, 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_release_accept", m_acc, 64'd1);
    set_instr(4'h1, 4'h3, 4'h0, 4'h0);
    tick();
    chk("b2b_accept", m_acc, 64'd1);
    in_valid = 1'b0;
    tick();
    retire(4'h5);

    // faulting instructions: no claims, no stalls
    send(4'hC, 4'h0, 4'h1, 4'h2, cyc);
    send(4'h2, 4'h0, RN, 4'h6, cyc);
    send(4'h6, 4'h0, 4'h6, 4'h6, cyc);
    chk("err_no_claim", cyc, 64'd1);
    retire(4'h6);
    send(4'h3, 4'h0, 4'h0, 4'h7, cyc);
    send(4'h6, 4'h0, 4'h7, RN, cyc);
    chk("err_no_stall", cyc, 64'd1);
    retire(4'h7);

    // same-cycle retire and re-claim of the stack pointer
    send(4'hA, 4'h0, 4'h1, 4'h0, cyc);
    retire(RSP);
    wb_valid = 1'b1;
    wb_dst   = RSP;
    send(4'hA, 4'h0, 4'h2, 4'h0, cyc);
    wb_valid = 1'b0;
    set_instr(4'h6, 4'h0, RSP, 4'h3);
    in_valid = 1'b1;
    tick();
    chk("set_wins_stall", m_acc, (SB_ON != 0) ? 64'd0 : 64'd1);
    in_valid = 1'b0;
    retire(RSP);
    tick();
    retire(4'h3);

    // flush drops the held output and every claim
    out_ready = 1'b0;
    send(4'h3, 4'h0, 4'h0, 4'h2, cyc);
    set_instr(4'h1, 4'h0, 4'h0, 4'h0);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    send(4'h6, 4'h0, 4'h2, 4'h2, cyc);
    chk("flush_clears_claim", cyc, 64'd1);
    retire(4'h2);

    // reset while an output is held
    out_ready = 1'b0;
    send(4'h6, 4'h0, 4'h1, 4'h3, cyc);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 64'd0);
    chk("async_rst_dste", out_dste, 64'hF);
    q.delete();
    foreach (pend[i]) pend[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(4'h6, 4'h0, 4'h3, 4'h3, cyc);
    chk("rst_clears_claim", cyc, 64'd1);
    retire(4'h3);

    // randomized traffic
    in_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!in_valid || m_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_instr(($urandom_range(0, 9) != 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(12, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_dst    = 4'($urandom_range(0, 15));
      if (wb_valid && $urandom_range(0, 3) != 0) begin
        int cand[$];
        for (int r = 0; r < 15; r++) if (pend[r]) cand.push_back(r);
        if (cand.size() > 0) wb_dst = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      flush = ($urandom_range(0, 59) == 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; flush = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
